// File: rtl/mouse_event_unit.sv
// mouse_event_unit
// ----------------
// Conditions raw mouse inputs for downstream logic:
//   * clamps the raw position to the legal screen area and registers it,
//   * debounces the left and right buttons with one small FSM per button,
//   * turns debounced press edges into click events and holds them in a
//     one-entry valid/ready register with a sticky lost-event flag.
//
// Parameters
//   COORD_W       coordinate width in bits
//   X_MAX, Y_MAX  largest legal x / y coordinate
//   DEBOUNCE_CYC  consecutive samples a button change must persist (>= 1)
//
// Ports
//   clk                  rising-edge clock for all logic
//   rst                  synchronous active-high reset
//   xpos_in, ypos_in     raw position
//   left_in, right_in    raw button levels
//   xpos_out, ypos_out   registered, clamped position
//   left_out, right_out  debounced button levels
//   evt_valid            click event pending
//   evt_ready            consumer accepts the pending event
//   evt_type             bit0 = left press, bit1 = right press
//   evt_xpos, evt_ypos   clamped position captured at the press
//   evt_overflow         sticky flag: a press was dropped while an event was stalled
module mouse_event_unit #(
  parameter int COORD_W      = 12,
  parameter int X_MAX        = 799,
  parameter int Y_MAX        = 599,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] xpos_in,
  input  logic [COORD_W-1:0] ypos_in,
  input  logic               left_in,
  input  logic               right_in,
  output logic [COORD_W-1:0] xpos_out,
  output logic [COORD_W-1:0] ypos_out,
  output logic               left_out,
  output logic               right_out,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [1:0]         evt_type,
  output logic [COORD_W-1:0] evt_xpos,
  output logic [COORD_W-1:0] evt_ypos,
  output logic               evt_overflow
);

  if (DEBOUNCE_CYC < 1) begin : g_param_check
    $error("mouse_event_unit: DEBOUNCE_CYC must be at least 1");
  end

  localparam int CNT_W = (DEBOUNCE_CYC < 1) ? 1 : $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [COORD_W-1:0] X_LIM    = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] Y_LIM    = COORD_W'(Y_MAX);

  typedef enum logic [1:0] {
    ST_UP     = 2'd0,
    ST_CHK_DN = 2'd1,
    ST_DOWN   = 2'd2,
    ST_CHK_UP = 2'd3
  } btn_state_e;

  // Index 0 is the left button, index 1 the right button.
  btn_state_e       state_r     [2];
  btn_state_e       state_nxt_s [2];
  logic [CNT_W-1:0] cnt_r       [2];
  logic [CNT_W-1:0] cnt_nxt_s   [2];
  logic [1:0]       raw_s;
  logic [1:0]       level_r;
  logic [1:0]       level_nxt_s;
  logic [1:0]       press_s;

  logic [COORD_W-1:0] cx_s;
  logic [COORD_W-1:0] cy_s;
  logic [COORD_W-1:0] xpos_r;
  logic [COORD_W-1:0] ypos_r;

  logic               evt_valid_r;
  logic               evt_valid_nxt_s;
  logic [1:0]         evt_type_r;
  logic [1:0]         evt_type_nxt_s;
  logic [COORD_W-1:0] evt_xpos_r;
  logic [COORD_W-1:0] evt_xpos_nxt_s;
  logic [COORD_W-1:0] evt_ypos_r;
  logic [COORD_W-1:0] evt_ypos_nxt_s;
  logic               evt_ovf_r;
  logic               evt_ovf_nxt_s;

  assign raw_s = {right_in, left_in};

  // Clamp raw position to the legal screen area (unsigned compare).
  always_comb begin
    cx_s = xpos_in;
    cy_s = ypos_in;
    if (xpos_in > X_LIM) begin
      cx_s = X_LIM;
    end else begin
      cx_s = xpos_in;
    end
    if (ypos_in > Y_LIM) begin
      cy_s = Y_LIM;
    end else begin
      cy_s = ypos_in;
    end
  end

  // Debounce next-state logic, one FSM per button; the count tracks how many
  // consecutive samples of the opposite level have been seen so far.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      state_nxt_s[b] = state_r[b];
      cnt_nxt_s[b]   = cnt_r[b];
      case (state_r[b])
        ST_UP: begin
          if (raw_s[b]) begin
            if (DEBOUNCE_CYC == 1) begin
              state_nxt_s[b] = ST_DOWN;
              cnt_nxt_s[b]   = {CNT_W{1'b0}};
            end else begin
              state_nxt_s[b] = ST_CHK_DN;
              cnt_nxt_s[b]   = CNT_W'(1);
            end
          end else begin
            state_nxt_s[b] = ST_UP;
            cnt_nxt_s[b]   = {CNT_W{1'b0}};
          end
        end
        ST_CHK_DN: begin
          if (!raw_s[b]) begin
            state_nxt_s[b] = ST_UP;
            cnt_nxt_s[b]   = {CNT_W{1'b0}};
          end else if (cnt_r[b] == CNT_LAST) begin
            state_nxt_s[b] = ST_DOWN;
            cnt_nxt_s[b]   = {CNT_W{1'b0}};
          end else begin
            state_nxt_s[b] = ST_CHK_DN;
            cnt_nxt_s[b]   = cnt_r[b] + CNT_W'(1);
          end
        end
        ST_DOWN: begin
          if (!raw_s[b]) begin
            if (DEBOUNCE_CYC == 1) begin
              state_nxt_s[b] = ST_UP;
              cnt_nxt_s[b]   = {CNT_W{1'b0}};
            end else begin
              state_nxt_s[b] = ST_CHK_UP;
              cnt_nxt_s[b]   = CNT_W'(1);
            end
          end else begin
            state_nxt_s[b] = ST_DOWN;
            cnt_nxt_s[b]   = {CNT_W{1'b0}};
          end
        end
        ST_CHK_UP: begin
          if (raw_s[b]) begin
            state_nxt_s[b] = ST_DOWN;
            cnt_nxt_s[b]   = {CNT_W{1'b0}};
          end else if (cnt_r[b] == CNT_LAST) begin
            state_nxt_s[b] = ST_UP;
            cnt_nxt_s[b]   = {CNT_W{1'b0}};
          end else begin
            state_nxt_s[b] = ST_CHK_UP;
            cnt_nxt_s[b]   = cnt_r[b] + CNT_W'(1);
          end
        end
        default: begin
          state_nxt_s[b] = ST_UP;
          cnt_nxt_s[b]   = {CNT_W{1'b0}};
        end
      endcase
      level_nxt_s[b] = (state_nxt_s[b] == ST_DOWN) || (state_nxt_s[b] == ST_CHK_UP);
    end
  end

  // A press is a debounced 0->1 transition happening on this edge.
  assign press_s = level_nxt_s & ~level_r;

  // Event register next-state: load on press unless stalled, clear on transfer.
  always_comb begin
    evt_valid_nxt_s = evt_valid_r;
    evt_type_nxt_s  = evt_type_r;
    evt_xpos_nxt_s  = evt_xpos_r;
    evt_ypos_nxt_s  = evt_ypos_r;
    evt_ovf_nxt_s   = evt_ovf_r;
    if (press_s != 2'b00) begin
      if (evt_valid_r && !evt_ready) begin
        // Stalled entry keeps its data; the new press is lost.
        evt_ovf_nxt_s = 1'b1;
      end else begin
        evt_valid_nxt_s = 1'b1;
        evt_type_nxt_s  = press_s;
        evt_xpos_nxt_s  = cx_s;
        evt_ypos_nxt_s  = cy_s;
      end
    end else if (evt_valid_r && evt_ready) begin
      evt_valid_nxt_s = 1'b0;
    end else begin
      evt_valid_nxt_s = evt_valid_r;
    end
  end

  // State and output registers; reset overrides every other update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        state_r[b] <= ST_UP;
        cnt_r[b]   <= {CNT_W{1'b0}};
      end
      level_r     <= 2'b00;
      xpos_r      <= {COORD_W{1'b0}};
      ypos_r      <= {COORD_W{1'b0}};
      evt_valid_r <= 1'b0;
      evt_type_r  <= 2'b00;
      evt_xpos_r  <= {COORD_W{1'b0}};
      evt_ypos_r  <= {COORD_W{1'b0}};
      evt_ovf_r   <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        state_r[b] <= state_nxt_s[b];
        cnt_r[b]   <= cnt_nxt_s[b];
      end
      level_r     <= level_nxt_s;
      xpos_r      <= cx_s;
      ypos_r      <= cy_s;
      evt_valid_r <= evt_valid_nxt_s;
      evt_type_r  <= evt_type_nxt_s;
      evt_xpos_r  <= evt_xpos_nxt_s;
      evt_ypos_r  <= evt_ypos_nxt_s;
      evt_ovf_r   <= evt_ovf_nxt_s;
    end
  end

  assign xpos_out     = xpos_r;
  assign ypos_out     = ypos_r;
  assign left_out     = level_r[0];
  assign right_out    = level_r[1];
  assign evt_valid    = evt_valid_r;
  assign evt_type     = evt_type_r;
  assign evt_xpos     = evt_xpos_r;
  assign evt_ypos     = evt_ypos_r;
  assign evt_overflow = evt_ovf_r;

endmodule

// File: doc/mouse_event_unit.md
MOUSE_EVENT_UNIT -- requirements
Module: mouse_event_unit

Interface
REQ-001 Parameter COORD_W, default 12: coordinate width in bits.
REQ-002 Parameter X_MAX, default 799: largest legal x coordinate.
REQ-003 Parameter Y_MAX, default 599: largest legal y coordinate.
REQ-004 Parameter DEBOUNCE_CYC, default 4: cycles a button change must persist; the design SHALL reject values below 1 at elaboration.
REQ-005 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 xpos_in, ypos_in  input  COORD_W  raw mouse position.
REQ-008 left_in, right_in  input  1  raw button levels.
REQ-009 xpos_out, ypos_out  output  COORD_W  registered, clamped position.
REQ-010 left_out, right_out  output  1  debounced button levels.
REQ-011 evt_valid  output  1  click event pending.
REQ-012 evt_ready  input  1  consumer accepts event.
REQ-013 evt_type  output  2  bit0 = left press, bit1 = right press.
REQ-014 evt_xpos, evt_ypos  output  COORD_W  clamped position captured at press.
REQ-015 evt_overflow  output  1  sticky lost-event flag.

Function
REQ-016 Clamp: cx = min(xpos_in, X_MAX) and cy = min(ypos_in, Y_MAX), unsigned compare; xpos_out/ypos_out SHALL equal cx/cy one cycle after sampling.
REQ-017 Each button SHALL have an independent FSM with states UP, CHK_DN, DOWN, CHK_UP and a counter of width clog2(DEBOUNCE_CYC+1).
REQ-018 UP: raw=1 -> CHK_DN, count=1; raw=0 -> stay UP.
REQ-019 CHK_DN: raw=0 -> UP, count=0; raw=1 and count=DEBOUNCE_CYC-1 -> DOWN, count=0; otherwise count+1.
REQ-020 DOWN and CHK_UP SHALL mirror UP and CHK_DN with raw polarity inverted.
REQ-021 With DEBOUNCE_CYC=1, UP/DOWN SHALL switch directly on the first differing sample.
REQ-022 The debounced level SHALL be 1 in DOWN and CHK_UP and 0 otherwise; it therefore changes on the DEBOUNCE_CYC-th consecutive edge sampling the new raw level.
REQ-023 A 0->1 transition of a debounced level SHALL raise a press; a 1->0 transition SHALL raise no event.
REQ-024 Left and right presses on the same edge SHALL form one event with evt_type=2'b11.
REQ-025 On a press edge, the one-entry event register SHALL load evt_type, evt_xpos=cx and evt_ypos=cy from that edge's inputs, and SHALL set evt_valid.
REQ-026 A transfer SHALL occur on an edge where evt_valid=1 and evt_ready=1; without a new press, evt_valid SHALL clear on that edge.
REQ-027 While evt_valid=1 and evt_ready=0, evt_type/evt_xpos/evt_ypos SHALL hold stable.
REQ-028 A press while evt_valid=1 and evt_ready=0 SHALL be dropped, and evt_overflow SHALL set and remain set until rst.
REQ-029 A press coinciding with a transfer SHALL load the new event, keep evt_valid=1 and leave evt_overflow unchanged.
REQ-030 evt_ready while evt_valid=0 SHALL have no effect.

Reset
REQ-031 On rst=1 at a clock edge, the block SHALL set all FSMs to UP, counters to 0, and xpos_out, ypos_out, left_out, right_out, evt_valid, evt_type, evt_xpos, evt_ypos and evt_overflow to 0.
REQ-032 Reset SHALL take priority over every other update, including a mid-debounce count or a pending event.
REQ-033 After rst deasserts, a press SHALL require a full DEBOUNCE_CYC consecutive samples of the new level.

Verification (defaults, DEBOUNCE_CYC=4)
REQ-034 xpos_in=1000, ypos_in=300 -> next cycle xpos_out=799, ypos_out=300; xpos_in=4095, ypos_in=4095 -> 799, 599.
REQ-035 left_in high for 3 cycles then low -> left_out stays 0 and evt_valid stays 0.
REQ-036 left_in held high, xpos_in=100, ypos_in=200, evt_ready=1 -> on the 4th edge left_out=1 and evt_valid=1 with evt_type=01 and coordinates 100/200; evt_valid is high for exactly one cycle.
REQ-037 evt_ready=0, first left press at (10,20), then release, then second press at (30,40) -> evt_valid stays 1 with data still (10,20), evt_overflow=1; raising evt_ready delivers only (10,20).
REQ-038 left_in and right_in rise on the same cycle and are held -> one event with evt_type=11.
REQ-039 left_in high for 2 cycles, then rst pulsed 1 cycle while left_in stays high -> left_out rises 4 edges after rst deasserts, not earlier.
